// File: rtl/ram_stream_engine_pkg.sv
// Shared opcode and state encodings for the RAM stream engine.
package ram_stream_engine_pkg;

    localparam logic OP_READ = 1'b0;
    localparam logic OP_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ram_stream_engine_fifo2.sv
// Two-entry valid/ready output buffer; the caller only pushes when a slot is free
// (or a pop happens in the same cycle).
module stream_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       cnt_q;
    logic             pop;

    assign pop       = out_valid && out_ready;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
    assign count     = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else if (push && !pop) begin
            cnt_q <= cnt_q + 2'd1;
        end else if (!push && pop) begin
            cnt_q <= cnt_q - 2'd1;
        end
    end

    // Word storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !pop) begin
            if (cnt_q == 2'd0) begin
                head_q <= push_data;
            end else begin
                tail_q <= push_data;
            end
        end else if (!push && pop) begin
            head_q <= tail_q;
        end else if (push && pop) begin
            if (cnt_q == 2'd1) begin
                head_q <= push_data;
            end else begin
                head_q <= tail_q;
                tail_q <= push_data;
            end
        end
    end

endmodule

// File: rtl/ram_stream_engine.sv
// Command-driven READ/FILL controller for one single-port RAM with 1-cycle read latency.
module ram_stream_engine
    import ram_stream_engine_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int ENTRIES = 256,
    localparam int AW      = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic             cmdOp,
    input  logic [AW-1:0]    cmdAddress,
    input  logic [AW:0]      cmdLength,
    input  logic [WIDTH-1:0] fillData,
    output logic [WIDTH-1:0] outData,
    output logic             outValid,
    input  logic             outReady,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    ramAddress,
    output logic [WIDTH-1:0] ramWriteData,
    output logic             ramWriteEnable,
    input  logic [WIDTH-1:0] ramReadData
);

    localparam logic [AW:0] ENTRIES_L = (AW+1)'(ENTRIES);

    state_t           state_q;
    state_t           state_d;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    addr_next;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      remain_q;
    logic [AW:0]      len_clamp;
    logic [WIDTH-1:0] fill_q;
    logic             rd_vld_p1;
    logic [1:0]       fifo_cnt;
    logic [2:0]       occ;
    logic             accept;
    logic             pop;
    logic             issue;
    logic             write;
    logic             drained;

    assign accept    = cmdValid && (state_q == IDLE);
    assign len_clamp = (cmdLength > ENTRIES_L) ? ENTRIES_L : cmdLength;
    assign base_addr = ({1'b0, cmdAddress} >= ENTRIES_L) ? AW'({1'b0, cmdAddress} - ENTRIES_L)
                                                         : cmdAddress;
    assign addr_next = (addr_q == AW'(ENTRIES - 1)) ? '0 : addr_q + AW'(1);

    // Words buffered plus the read returning this cycle, minus any pop, must leave a free slot.
    assign pop     = outValid && outReady;
    assign occ     = {1'b0, fifo_cnt} + {2'b00, rd_vld_p1};
    assign issue   = (state_q == READ) && (remain_q != '0) && (occ < (3'd2 + {2'b00, pop}));
    assign write   = (state_q == FILL);
    assign drained = (remain_q == '0) && !rd_vld_p1 &&
                     ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (len_clamp == '0) begin
                        state_d = DONE;
                    end else if (cmdOp == OP_FILL) begin
                        state_d = FILL;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            FILL:    if (remain_q == (AW+1)'(1)) state_d = DONE;
            READ:    if (drained) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmdReady       = (state_q == IDLE);
        busy           = (state_q == FILL) || (state_q == READ);
        done           = (state_q == DONE);
        ramWriteEnable = write && !rst;
        ramAddress     = addr_q;
        ramWriteData   = fill_q;
    end

    // p0 -> p1: address issued this cycle, RAM data returns next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            remain_q  <= '0;
            fill_q    <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= issue;
            if (accept) begin
                addr_q   <= base_addr;
                remain_q <= len_clamp;
                fill_q   <= fillData;
            end else if (write || issue) begin
                addr_q   <= addr_next;
                remain_q <= remain_q - (AW+1)'(1);
            end
        end
    end

    // p1 -> p2: returned word enters the output buffer
    stream_fifo2 #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_vld_p1),
        .push_data(ramReadData),
        .out_valid(outValid),
        .out_data (outData),
        .out_ready(outReady),
        .count    (fifo_cnt)
    );

endmodule

// File: tb/tb_ram_stream_engine.sv
// Scoreboard bench for ram_stream_engine with a behavioural RAM and reference memory.
module tb_ram_stream_engine;

    localparam int WIDTH   = 8;
    localparam int ENTRIES = 8;
    localparam int AW      = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmdValid = 1'b0;
    logic             cmdReady;
    logic             cmdOp = 1'b0;
    logic [AW-1:0]    cmdAddress = '0;
    logic [AW:0]      cmdLength = '0;
    logic [WIDTH-1:0] fillData = '0;
    logic [WIDTH-1:0] outData;
    logic             outValid;
    logic             outReady;
    logic             busy;
    logic             done;
    logic [AW-1:0]    ramAddress;
    logic [WIDTH-1:0] ramWriteData;
    logic             ramWriteEnable;
    logic [WIDTH-1:0] ramReadData;

    always #5 clk = ~clk;

    ram_stream_engine #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
        .cmdAddress(cmdAddress), .cmdLength(cmdLength), .fillData(fillData),
        .outData(outData), .outValid(outValid), .outReady(outReady), .busy(busy),
        .done(done), .ramAddress(ramAddress), .ramWriteData(ramWriteData),
        .ramWriteEnable(ramWriteEnable), .ramReadData(ramReadData)
    );

    // Single-port RAM with registered read
    logic [WIDTH-1:0] ram [ENTRIES];
    always @(posedge clk) begin
        if (ramWriteEnable) ram[ramAddress] <= ramWriteData;
        ramReadData <= ram[ramAddress];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: memory image plus expected output and write streams
    logic [WIDTH-1:0]    ref_mem [ENTRIES];
    logic [WIDTH-1:0]    exp_rd[$];
    logic [AW+WIDTH-1:0] exp_wr[$];
    int done_exp  = 0;
    int done_seen = 0;

    task automatic model_cmd(input bit op, input int addr, input int len, input logic [WIDTH-1:0] fd);
        int n;
        n = (len > ENTRIES) ? ENTRIES : len;
        for (int i = 0; i < n; i++) begin
            int a;
            a = (addr + i) % ENTRIES;
            if (op) begin
                ref_mem[a] = fd;
                exp_wr.push_back({AW'(a), fd});
            end else begin
                exp_rd.push_back(ref_mem[a]);
            end
        end
        done_exp++;
    endtask

    task automatic send(input bit op, input int addr, input int len, input logic [WIDTH-1:0] fd);
        int t;
        t = 0;
        while (!cmdReady && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk(t < 300, "cmd_ready_wait", t, 0);
        cmdValid   = 1'b1;
        cmdOp      = op;
        cmdAddress = AW'(addr);
        cmdLength  = (AW+1)'(len);
        fillData   = fd;
        model_cmd(op, addr, len, fd);
        @(posedge clk); #1;
        cmdValid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (!cmdReady && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk(t < 300, {name, "_timeout"}, t, 0);
        chk(done_seen == done_exp, {name, "_done_count"}, done_seen, done_exp);
        chk(exp_rd.size() == 0, {name, "_words_left"}, exp_rd.size(), 0);
        chk(exp_wr.size() == 0, {name, "_writes_left"}, exp_wr.size(), 0);
    endtask

    // Sink readiness: 0 held high, 1 pattern 1,0,0,..., 2 random, 3 held low
    int rdy_mode = 0;
    int cyc      = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        case (rdy_mode)
            0:       outReady = 1'b1;
            1:       outReady = (cyc % 3 == 0);
            2:       outReady = 1'($urandom_range(0, 1));
            default: outReady = 1'b0;
        endcase
    end

    // Monitor: pops expected words/writes whenever the DUT presents them
    logic             prev_stall = 1'b0;
    logic             prev_rst   = 1'b1;
    logic [WIDTH-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (rst && ramWriteEnable) chk(1'b0 == ramWriteEnable, "write_during_reset", ramWriteEnable, 0);
        if (!rst) begin
            if (prev_stall && !prev_rst) begin
                chk(outValid == 1'b1, "stall_valid", outValid, 1);
                chk(outData == prev_data, "stall_data", outData, prev_data);
            end
            if (outValid && outReady) begin
                chk(exp_rd.size() != 0, "rd_extra_word", outData, 0);
                if (exp_rd.size() != 0) begin
                    logic [WIDTH-1:0] e;
                    e = exp_rd.pop_front();
                    chk(outData == e, "rd_data", outData, e);
                end
            end
            if (ramWriteEnable) begin
                chk(exp_wr.size() != 0, "wr_extra", {ramAddress, ramWriteData}, 0);
                if (exp_wr.size() != 0) begin
                    logic [AW+WIDTH-1:0] w;
                    w = exp_wr.pop_front();
                    chk({ramAddress, ramWriteData} == w, "wr_addr_data", {ramAddress, ramWriteData}, w);
                end
            end
            if (done) done_seen++;
        end
        prev_stall = outValid && !outReady;
        prev_data  = outData;
        prev_rst   = rst;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0t, required finish earlier", $time);
        $fatal(1);
    end

    logic [AW-1:0] wrap_addr [4];

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(cmdReady == 1'b1, "reset_cmdReady", cmdReady, 1);
        chk(busy == 1'b0, "reset_busy", busy, 0);
        chk(outValid == 1'b0, "reset_outValid", outValid, 0);
        chk(done == 1'b0, "reset_done", done, 0);
        chk(ramWriteEnable == 1'b0, "reset_we", ramWriteEnable, 0);
        chk(ramAddress == '0, "reset_addr", ramAddress, 0);
        @(posedge clk); #1;

        send(1'b1, 0, ENTRIES, 8'h00);
        wait_idle("clear");

        // FILL 4..6 with 0xA5, cycle by cycle
        send(1'b1, 4, 3, 8'hA5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk(ramWriteEnable == (k <= 3), "fill_we_cycle", ramWriteEnable, k <= 3);
            chk(done == (k == 4), "fill_done_cycle", done, k == 4);
            chk(cmdReady == (k == 5), "fill_ready_cycle", cmdReady, k == 5);
        end
        wait_idle("fill");

        for (int i = 0; i < ENTRIES; i++) begin
            send(1'b1, i, 1, 8'(8'h10 + i));
            wait_idle("preload");
        end

        // READ latency with sink always ready
        rdy_mode = 0;
        send(1'b0, 0, 4, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) chk(ramAddress == '0, "read_first_addr", ramAddress, 0);
            chk(outValid == (k == 3), "read_latency_valid", outValid, k == 3);
            chk(busy == 1'b1, "read_busy", busy, 1);
        end
        wait_idle("read_full_rate");

        rdy_mode = 1;
        send(1'b0, 0, 4, 8'h00);
        wait_idle("read_stalled");

        // Wrap-around address sequence 6,7,0,1
        rdy_mode = 0;
        wrap_addr[0] = 3'd6; wrap_addr[1] = 3'd7; wrap_addr[2] = 3'd0; wrap_addr[3] = 3'd1;
        send(1'b0, 6, 4, 8'h00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk(ramAddress == wrap_addr[k], "wrap_addr", ramAddress, wrap_addr[k]);
        end
        wait_idle("read_wrap");

        send(1'b1, 3, 0, 8'hEE);
        wait_idle("fill_len0");
        send(1'b0, 5, 0, 8'h00);
        wait_idle("read_len0");
        rdy_mode = 2;
        send(1'b0, 2, ENTRIES + 3, 8'h00);
        wait_idle("read_clamp");
        send(1'b1, 5, ENTRIES + 3, 8'h3C);
        wait_idle("fill_clamp");
        send(1'b0, 0, ENTRIES, 8'h00);
        wait_idle("read_after_clamp");

        // Reset while a word sits in the buffer
        rdy_mode = 3;
        send(1'b0, 0, 4, 8'h00);
        begin
            int t;
            t = 0;
            while (!outValid && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            chk(t < 20, "abort_wait_valid", t, 0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd.delete();
        done_exp--;
        chk(outValid == 1'b0, "abort_outValid", outValid, 0);
        chk(busy == 1'b0, "abort_busy", busy, 0);
        chk(cmdReady == 1'b1, "abort_cmdReady", cmdReady, 1);
        chk(done == 1'b0, "abort_done", done, 0);
        rdy_mode = 0;
        send(1'b1, 1, 3, 8'h5C);
        wait_idle("fill_after_abort");
        send(1'b0, 0, ENTRIES, 8'h00);
        wait_idle("read_after_abort");

        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            send(1'($urandom_range(0, 1)), int'($urandom_range(0, ENTRIES - 1)),
                 int'($urandom_range(0, ENTRIES + 3)), 8'($urandom_range(0, 255)));
            wait_idle("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
